// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment readback path: segment patterns,
// the error nibble and the per-dwell state encoding.
package seg7_pkg;

  // Active-high patterns on seg[6:0] = {a,b,c,d,e,f,g}
  localparam logic [6:0] SEG_0 = 7'h7E;
  localparam logic [6:0] SEG_1 = 7'h30;
  localparam logic [6:0] SEG_2 = 7'h6D;
  localparam logic [6:0] SEG_3 = 7'h79;
  localparam logic [6:0] SEG_4 = 7'h33;
  localparam logic [6:0] SEG_5 = 7'h5B;
  localparam logic [6:0] SEG_6 = 7'h5F;
  localparam logic [6:0] SEG_7 = 7'h70;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h7B;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h1F;
  localparam logic [6:0] SEG_C = 7'h4E;
  localparam logic [6:0] SEG_D = 7'h3D;
  localparam logic [6:0] SEG_E = 7'h4F;
  localparam logic [6:0] SEG_F = 7'h47;

  localparam logic [3:0] ERR_NIBBLE = 4'hF;

  typedef enum logic [1:0] {
    WAIT_SEL = 2'd0,
    SETTLE   = 2'd1,
    CAPTURED = 2'd2
  } dwell_state_e;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational segment-pattern to BCD nibble decoder.
// Define SEG7_HEX_DECODE_EN to also accept the A-F hex glyphs.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] nibble,
  output logic       err
);

  always_comb begin
    nibble = ERR_NIBBLE;
    err    = 1'b0;
    case (seg)
      SEG_0: nibble = 4'h0;
      SEG_1: nibble = 4'h1;
      SEG_2: nibble = 4'h2;
      SEG_3: nibble = 4'h3;
      SEG_4: nibble = 4'h4;
      SEG_5: nibble = 4'h5;
      SEG_6: nibble = 4'h6;
      SEG_7: nibble = 4'h7;
      SEG_8: nibble = 4'h8;
      SEG_9: nibble = 4'h9;
`ifdef SEG7_HEX_DECODE_EN
      SEG_A: nibble = 4'hA;
      SEG_B: nibble = 4'hB;
      SEG_C: nibble = 4'hC;
      SEG_D: nibble = 4'hD;
      SEG_E: nibble = 4'hE;
      SEG_F: nibble = 4'hF;
`endif
      // Blank and any unknown glyph land here
      default: begin
        nibble = ERR_NIBBLE;
        err    = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Samples a multiplexed 7-segment bus, captures each digit once it has been
// stable for STABLE_CYC cycles, and presents full frames on valid/ready.
// Hex glyph decode is enabled by defining SEG7_HEX_DECODE_EN.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int NDIG       = 4,
  parameter int STABLE_CYC = 4,
  parameter int CNT_W      = $clog2(STABLE_CYC + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [6:0]          seg,
  input  logic [NDIG-1:0]     an,
  input  logic                frame_ready,
  output logic                frame_valid,
  output logic [4*NDIG-1:0]   bcd_digits,
  output logic [NDIG-1:0]     digit_err,
  output logic                overrun
);

  localparam logic [CNT_W-1:0] STABLE_LIM = CNT_W'(STABLE_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  dwell_state_e             state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [NDIG-1:0]          an_q, an_d;
  logic [6:0]               seg_q, seg_d;
  logic [NDIG-1:0]          mask_q, mask_d;
  logic [NDIG-1:0][3:0]     work_nib_q, work_nib_d;
  logic [NDIG-1:0]          work_err_q, work_err_d;
  logic                     frame_valid_q, frame_valid_d;
  logic [4*NDIG-1:0]        bcd_q, bcd_d;
  logic [NDIG-1:0]          err_q, err_d;
  logic                     overrun_q, overrun_d;

  logic                     an_onehot;
  logic                     capture;
  logic                     frame_full;
  logic [3:0]               dec_nibble;
  logic                     dec_err;

  seg7_pattern_decode u_decode (
    .seg    (seg),
    .nibble (dec_nibble),
    .err    (dec_err)
  );

  assign an_onehot  = (an != '0) && ((an & (an - NDIG'(1))) == '0);
  assign frame_full = &mask_q;

  // Dwell tracking: count identical consecutive samples on one digit
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    an_d    = an;
    seg_d   = seg;
    capture = 1'b0;
    if (!an_onehot) begin
      state_d = WAIT_SEL;
      cnt_d   = '0;
    end else begin
      case (state_q)
        WAIT_SEL: begin
          state_d = SETTLE;
          cnt_d   = CNT_ONE;
        end
        SETTLE: begin
          if (an == an_q && seg == seg_q) cnt_d = cnt_q + CNT_ONE;
          else                            cnt_d = CNT_ONE;
        end
        CAPTURED: begin
          if (an != an_q) begin
            state_d = SETTLE;
            cnt_d   = CNT_ONE;
          end
        end
        default: begin
          state_d = WAIT_SEL;
          cnt_d   = '0;
        end
      endcase
      // Capture on the edge where the count reaches the threshold
      if (state_d == SETTLE && cnt_d == STABLE_LIM) begin
        capture = 1'b1;
        state_d = CAPTURED;
      end
    end
  end

  // Frame assembly and output buffer
  always_comb begin
    mask_d        = frame_full ? '0 : mask_q;
    work_nib_d    = work_nib_q;
    work_err_d    = work_err_q;
    frame_valid_d = frame_valid_q;
    bcd_d         = bcd_q;
    err_d         = err_q;
    overrun_d     = overrun_q;

    if (frame_full) begin
      if (!frame_valid_q || frame_ready) begin
        bcd_d         = work_nib_q;
        err_d         = work_err_q;
        frame_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (frame_valid_q && frame_ready) begin
      frame_valid_d = 1'b0;
    end

    if (capture) begin
      for (int i = 0; i < NDIG; i++) begin
        if (an[i]) begin
          work_nib_d[i] = dec_nibble;
          work_err_d[i] = dec_err;
          mask_d[i]     = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= WAIT_SEL;
      cnt_q         <= '0;
      an_q          <= '0;
      seg_q         <= '0;
      mask_q        <= '0;
      work_nib_q    <= '0;
      work_err_q    <= '0;
      frame_valid_q <= 1'b0;
      bcd_q         <= '0;
      err_q         <= '0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      mask_q        <= mask_d;
      work_nib_q    <= work_nib_d;
      work_err_q    <= work_err_d;
      frame_valid_q <= frame_valid_d;
      bcd_q         <= bcd_d;
      err_q         <= err_d;
      overrun_q     <= overrun_d;
    end
  end

  assign frame_valid = frame_valid_q;
  assign bcd_digits  = bcd_q;
  assign digit_err   = err_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Randomised and directed bench for seg7_scan_decoder against a
// sliding-window behavioural model of the scan readback.
module tb_seg7_scan_decoder;

  localparam int NDIG       = 4;
  localparam int STABLE_CYC = 4;
  localparam int CNT_W      = $clog2(STABLE_CYC + 1);

  localparam logic [6:0] PATS [0:15] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
  };

  logic                clk = 1'b0;
  logic                rst;
  logic [6:0]          seg;
  logic [NDIG-1:0]     an;
  logic                frame_ready;
  logic                frame_valid;
  logic [4*NDIG-1:0]   bcd_digits;
  logic [NDIG-1:0]     digit_err;
  logic                overrun;

  always #5 clk = ~clk;

  seg7_scan_decoder #(
    .NDIG       (NDIG),
    .STABLE_CYC (STABLE_CYC),
    .CNT_W      (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .seg         (seg),
    .an          (an),
    .frame_ready (frame_ready),
    .frame_valid (frame_valid),
    .bcd_digits  (bcd_digits),
    .digit_err   (digit_err),
    .overrun     (overrun)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // {err, nibble} from the glyph table
  function automatic logic [4:0] ref_decode(input logic [6:0] p);
    for (int d = 0; d < 10; d++)
      if (p == PATS[d]) return {1'b0, 4'(d)};
`ifdef SEG7_HEX_DECODE_EN
    for (int d = 10; d < 16; d++)
      if (p == PATS[d]) return {1'b0, 4'(d)};
`endif
    return 5'h1F;
  endfunction

  // Model: a digit is captured when the last STABLE_CYC samples are all the
  // same valid (an,seg) pair and nothing was captured yet while an held.
  logic [NDIG+6:0]     hist [$];
  logic [NDIG-1:0]     m_prev_an;
  logic                m_done;
  logic [NDIG-1:0]     m_mask;
  logic [3:0]          m_work [NDIG];
  logic [NDIG-1:0]     m_werr;
  logic                m_valid;
  logic [4*NDIG-1:0]   m_bcd;
  logic [NDIG-1:0]     m_err;
  logic                m_ovr;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      hist.delete();
      m_prev_an <= '0;
      m_done    <= 1'b0;
      m_mask    <= '0;
      for (int i = 0; i < NDIG; i++) m_work[i] <= 4'h0;
      m_werr    <= '0;
      m_valid   <= 1'b0;
      m_bcd     <= '0;
      m_err     <= '0;
      m_ovr     <= 1'b0;
    end else begin : model_step
      logic            valid_an, done_now, same, cap;
      logic [4:0]      dec;
      logic [NDIG-1:0] nmask;
      valid_an = ($countones(an) == 1);
      if (!valid_an) hist.delete();
      else begin
        hist.push_back({an, seg});
        if (hist.size() > STABLE_CYC) void'(hist.pop_front());
      end
      done_now = (valid_an && an == m_prev_an) ? m_done : 1'b0;
      same = (hist.size() == STABLE_CYC);
      for (int k = 0; k < hist.size(); k++)
        if (hist[k] != hist[0]) same = 1'b0;
      cap = valid_an && !done_now && same;
      m_done    <= valid_an && (done_now || cap);
      m_prev_an <= valid_an ? an : '0;

      nmask = (&m_mask) ? '0 : m_mask;
      if (&m_mask) begin
        if (!m_valid || frame_ready) begin
          for (int i = 0; i < NDIG; i++) m_bcd[4*i +: 4] <= m_work[i];
          m_err   <= m_werr;
          m_valid <= 1'b1;
        end else begin
          m_ovr <= 1'b1;
        end
      end else if (m_valid && frame_ready) begin
        m_valid <= 1'b0;
      end
      if (cap) begin
        dec = ref_decode(seg);
        for (int i = 0; i < NDIG; i++)
          if (an[i]) begin
            m_work[i] <= dec[3:0];
            m_werr[i] <= dec[4];
            nmask[i]   = 1'b1;
          end
      end
      m_mask <= nmask;
    end
  end

  // Per-cycle compare plus a record of each frame_valid rising edge
  int                fv_count = 0;
  logic              fv_prev  = 1'b0;
  logic [4*NDIG-1:0] fv_bcd   = '0;
  logic [NDIG-1:0]   fv_err   = '0;

  always @(negedge clk) begin
    if (!rst) begin
      chk("frame_valid", 32'(frame_valid), 32'(m_valid));
      chk("bcd_digits",  32'(bcd_digits),  32'(m_bcd));
      chk("digit_err",   32'(digit_err),   32'(m_err));
      chk("overrun",     32'(overrun),     32'(m_ovr));
      if (frame_valid && !fv_prev) begin
        fv_count++;
        fv_bcd = bcd_digits;
        fv_err = digit_err;
      end
      fv_prev = frame_valid;
    end else begin
      fv_prev = 1'b0;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic dwell(input int idx, input logic [6:0] p, input int n);
    an      = '0;
    an[idx] = 1'b1;
    seg     = p;
    step(n);
  endtask

  task automatic idle(input int n);
    an  = '0;
    seg = '0;
    step(n);
  endtask

  task automatic scan4(input logic [6:0] p0, input logic [6:0] p1,
                       input logic [6:0] p2, input logic [6:0] p3, input int n);
    dwell(0, p0, n);
    dwell(1, p1, n);
    dwell(2, p2, n);
    dwell(3, p3, n);
  endtask

  initial begin
    int base;
    int idx;
    int len;
    logic [6:0] p;

    rst = 1'b1; an = '0; seg = '0; frame_ready = 1'b1;
    step(3);
    chk("reset_frame_valid", 32'(frame_valid), 32'h0);
    chk("reset_bcd",         32'(bcd_digits),  32'h0);
    chk("reset_err",         32'(digit_err),   32'h0);
    chk("reset_overrun",     32'(overrun),     32'h0);
    rst = 1'b0;
    step(1);

    // Basic scan, 6-cycle dwells
    base = fv_count;
    scan4(7'h79, 7'h7E, 7'h30, 7'h6D, 6);
    idle(2);
    chk("basic_frames", 32'(fv_count - base), 32'd1);
    chk("basic_bcd",    32'(fv_bcd), 32'h2103);
    chk("basic_err",    32'(fv_err), 32'h0);
    chk("basic_pulse",  32'(frame_valid), 32'h0);

    // Short dwell is not captured, full dwell completes the frame
    base = fv_count;
    dwell(0, 7'h7E, 3);
    idle(2);
    dwell(1, 7'h33, 6);
    dwell(2, 7'h5B, 6);
    dwell(3, 7'h7B, 6);
    idle(3);
    chk("short_dwell_no_frame", 32'(fv_count - base), 32'd0);
    dwell(0, 7'h7E, 4);
    idle(3);
    chk("short_dwell_frame", 32'(fv_count - base), 32'd1);
    chk("short_dwell_bcd",   32'(fv_bcd), 32'h9540);

    // Segment glitch restarts settling
    base = fv_count;
    dwell(0, 7'h79, 2);
    dwell(0, 7'h7F, 1);
    dwell(0, 7'h79, 4);
    dwell(1, 7'h30, 5);
    dwell(2, 7'h30, 5);
    dwell(3, 7'h30, 5);
    idle(3);
    chk("glitch_frame", 32'(fv_count - base), 32'd1);
    chk("glitch_bcd",   32'(fv_bcd), 32'h1113);

    // Multi-hot enables capture nothing
    base = fv_count;
    dwell(0, 7'h5F, 5);
    dwell(1, 7'h70, 5);
    dwell(2, 7'h7F, 5);
    an = 4'b0011; seg = 7'h7B;
    step(10);
    idle(2);
    chk("multihot_no_frame", 32'(fv_count - base), 32'd0);
    dwell(3, 7'h6D, 5);
    idle(3);
    chk("multihot_frame", 32'(fv_count - base), 32'd1);
    chk("multihot_bcd",   32'(fv_bcd), 32'h2876);

    // Back-pressure: second frame dropped, overrun set
    frame_ready = 1'b0;
    scan4(7'h7F, 7'h70, 7'h5F, 7'h5B, 5);
    scan4(7'h30, 7'h30, 7'h30, 7'h30, 5);
    idle(3);
    chk("hold_valid",   32'(frame_valid), 32'h1);
    chk("hold_bcd",     32'(bcd_digits),  32'h5678);
    chk("hold_overrun", 32'(overrun),     32'h1);
    frame_ready = 1'b1;
    step(1);
    chk("accept_drop",  32'(frame_valid), 32'h0);

    // Hex glyph on digit 1
    base = fv_count;
    scan4(7'h7E, 7'h77, 7'h7E, 7'h7E, 5);
    idle(3);
    chk("hex_frame", 32'(fv_count - base), 32'd1);
`ifdef SEG7_HEX_DECODE_EN
    chk("hex_bcd", 32'(fv_bcd), 32'h00A0);
    chk("hex_err", 32'(fv_err), 32'h0);
`else
    chk("hex_bcd", 32'(fv_bcd), 32'h00F0);
    chk("hex_err", 32'(fv_err), 32'h2);
`endif

    // Asynchronous reset mid-scan with a frame held on the outputs
    frame_ready = 1'b0;
    scan4(7'h30, 7'h6D, 7'h79, 7'h33, 5);
    idle(2);
    dwell(0, 7'h5B, 2);
    an = 4'b0010; seg = 7'h7B;
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_frame_valid", 32'(frame_valid), 32'h0);
    chk("arst_bcd",         32'(bcd_digits),  32'h0);
    chk("arst_err",         32'(digit_err),   32'h0);
    chk("arst_overrun",     32'(overrun),     32'h0);
    step(2);
    rst = 1'b0;
    frame_ready = 1'b1;

    // Random scanning checked cycle by cycle against the model
    idx = 0;
    repeat (350) begin
      case ($urandom_range(0, 9))
        0:       an = '0;
        1:       an = NDIG'($urandom);
        default: begin
          idx = ($urandom_range(0, 3) == 0) ? $urandom_range(0, NDIG - 1) : (idx + 1) % NDIG;
          an = '0;
          an[idx] = 1'b1;
        end
      endcase
      case ($urandom_range(0, 7))
        0:       p = 7'($urandom);
        1:       p = 7'h00;
        default: p = PATS[$urandom_range(0, 15)];
      endcase
      len = $urandom_range(1, 8);
      for (int c = 0; c < len; c++) begin
        seg = ($urandom_range(0, 9) == 0) ? 7'($urandom) : p;
        frame_ready = ($urandom_range(0, 3) != 0);
        step(1);
      end
    end
    frame_ready = 1'b1;
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
